// File: rtl/neopix_ws2812_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | neopix_ws2812_tx : WS2812 one-wire encoder, double-buffered GRB pixels,   |
// |                    MSB first, latch gap at frame end.                     |
// | Optional: NEOPIX_UNDERRUN_EN adds the sticky UNDERRUN flag.               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module neopix_ws2812_tx #(
  parameter int unsigned T0H_CYC   = 20,
  parameter int unsigned T1H_CYC   = 40,
  parameter int unsigned TBIT_CYC  = 63,
  parameter int unsigned LATCH_CYC = 15000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] PIX_DATA,
  input  logic        PIX_LAST,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  output logic        DO,
  output logic        BUSY,
  output logic        FRAME_DONE
`ifdef NEOPIX_UNDERRUN_EN
  , output logic      UNDERRUN
`endif
);

  localparam int unsigned CNT_MAX = (LATCH_CYC > TBIT_CYC) ? LATCH_CYC : TBIT_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] c_t0h        = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] c_t1h        = CNT_W'(T1H_CYC);
  localparam logic [CNT_W-1:0] c_tbit_last  = CNT_W'(TBIT_CYC - 1);
  localparam logic [CNT_W-1:0] c_latch_last = CNT_W'(LATCH_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIT   = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [23:0]      shift_q, shift_d;
  logic             cur_last_q, cur_last_d;
  logic [23:0]      hold_data_q, hold_data_d;
  logic             hold_last_q, hold_last_d;
  logic             hold_full_q, hold_full_d;
  logic             do_q, do_d;
  logic             frame_done_q, frame_done_d;
  logic             load_shift;
`ifdef NEOPIX_UNDERRUN_EN
  logic             underrun_q, underrun_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    cur_last_d   = cur_last_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    frame_done_d = 1'b0;
    load_shift   = 1'b0;
`ifdef NEOPIX_UNDERRUN_EN
    underrun_d   = underrun_q;
`endif

    if (PIX_VALID && !hold_full_q) begin
      hold_data_d = PIX_DATA;
      hold_last_d = PIX_LAST;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load_shift = 1'b1;
          state_d    = ST_BIT;
        end
      end
      ST_BIT: begin
        if (cnt_q == c_tbit_last) begin
          cnt_d = '0;
          if (bit_idx_q == 5'd0) begin
            // LAST wins over a waiting pixel: the frame must be latched first.
            if (cur_last_q) begin
              state_d = ST_LATCH;
            end else if (hold_full_q) begin
              load_shift = 1'b1;
            end else begin
              state_d = ST_LATCH;
`ifdef NEOPIX_UNDERRUN_EN
              underrun_d = 1'b1;
`endif
            end
          end else begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (cnt_q == c_latch_last) begin
          cnt_d        = '0;
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_shift) begin
      shift_d     = hold_data_q;
      cur_last_d  = hold_last_q;
      hold_full_d = 1'b0;
      cnt_d       = '0;
      bit_idx_d   = 5'd23;
    end

    // DO is registered, so it is decoded from the values the counters take next.
    do_d = (state_d == ST_BIT) && (cnt_d < (shift_d[23] ? c_t1h : c_t0h));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      cur_last_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      do_q         <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef NEOPIX_UNDERRUN_EN
      underrun_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      cur_last_q   <= cur_last_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      do_q         <= do_d;
      frame_done_q <= frame_done_d;
`ifdef NEOPIX_UNDERRUN_EN
      underrun_q   <= underrun_d;
`endif
    end
  end

  assign PIX_READY  = ~hold_full_q;
  assign DO         = do_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign FRAME_DONE = frame_done_q;
`ifdef NEOPIX_UNDERRUN_EN
  assign UNDERRUN   = underrun_q;
`endif

endmodule
`default_nettype wire
